// File: rtl/clk_div_arbiter_if.sv
// Requester/divider bundle shared between the clock-divider arbiter and its users.
// The arbiter connects through the slave modport; the requester side drives the master modport.
interface clk_div_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   factor;
  logic [NREQ-1:0]      gnt;
  logic [2:0]           grant_id;
  logic                 busy;
  logic [31:0]          div_factor;
  logic                 div_reset;

  modport master (
    output req, factor,
    input  gnt, grant_id, busy, div_factor, div_reset
  );

  modport slave (
    input  req, factor,
    output gnt, grant_id, busy, div_factor, div_reset
  );
endinterface

// File: rtl/clk_div_arbiter.sv
// Round-robin arbiter handing one programmable clock divider to NREQ requesters.
// The winner's factor is loaded under divider reset; the grant follows a settle period.
module clk_div_arbiter #(
  parameter int NREQ          = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               reset,
  clk_div_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_GRANTED, S_RELEASE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
  localparam logic [2:0] PTR_RESET   = 3'(NREQ - 1);

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [2:0]        ptr, ptr_nxt;
  logic [2:0]        id_q, id_nxt;
  logic [31:0]       factor_q, factor_nxt;
  logic [NREQ-1:0]   gnt_q, gnt_nxt;
  logic              busy_q, busy_nxt;
  logic              dr_q, dr_nxt;
  logic              owner_req;
  logic [2:0]        pick;

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] idx);
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREQ; i++) oh[i] = (idx == 3'(i));
    return oh;
  endfunction

  // Lowest requester above the pointer wins; otherwise wrap to the lowest overall.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req, input logic [2:0] p);
    logic [2:0] hi, lo;
    logic       found_hi;
    hi = '0;
    lo = '0;
    found_hi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i > int'(p)) begin
          hi       = 3'(i);
          found_hi = 1'b1;
        end
        lo = 3'(i);
      end
    end
    return found_hi ? hi : lo;
  endfunction

  function automatic logic [31:0] clamp_factor(input logic [32*NREQ-1:0] f, input logic [2:0] idx);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx == 3'(i)) v = f[32*i +: 32];
    end
    return (v < 32'd2) ? 32'd2 : v;
  endfunction

  assign owner_req = |(bus.req & onehot(id_q));
  assign pick      = rr_pick(bus.req, ptr);

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ptr      <= PTR_RESET;
      id_q     <= '0;
      factor_q <= 32'd2;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      dr_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ptr      <= ptr_nxt;
      id_q     <= id_nxt;
      factor_q <= factor_nxt;
      gnt_q    <= gnt_nxt;
      busy_q   <= busy_nxt;
      dr_q     <= dr_nxt;
    end
  end

  // An owner dropping its request aborts LOAD/SETTLE/GRANTED alike.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ptr_nxt    = ptr;
    id_nxt     = id_q;
    factor_nxt = factor_q;
    case (state)
      S_IDLE: begin
        if (|bus.req) begin
          state_nxt  = S_LOAD;
          id_nxt     = pick;
          factor_nxt = clamp_factor(bus.factor, pick);
        end
      end
      S_LOAD: begin
        if (!owner_req) begin
          state_nxt = S_RELEASE;
        end else if (SETTLE_CYCLES == 0) begin
          state_nxt = S_GRANTED;
        end else begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end
      end
      S_SETTLE: begin
        if (!owner_req) begin
          state_nxt = S_RELEASE;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = S_GRANTED;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_GRANTED: begin
        if (!owner_req) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        ptr_nxt   = id_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    gnt_nxt  = (state_nxt == S_GRANTED) ? onehot(id_nxt) : '0;
    busy_nxt = (state_nxt != S_IDLE);
    dr_nxt   = (state_nxt == S_IDLE) || (state_nxt == S_LOAD) || (state_nxt == S_RELEASE);
  end

  assign bus.gnt        = gnt_q;
  assign bus.grant_id   = id_q;
  assign bus.busy       = busy_q;
  assign bus.div_factor = factor_q;
  assign bus.div_reset  = dr_q;

endmodule

// File: tb/tb_clk_div_arbiter.sv
// Bench for clk_div_arbiter: vector table, round-robin and reset sequences, then random
// traffic checked against a timestamp-based model of the arbitration rules.
module tb_clk_div_arbiter;
  localparam int NREQ   = 4;
  localparam int SETTLE = 4;

  logic clk_i = 1'b0;
  logic rst;
  always #5 clk_i = ~clk_i;

  clk_div_arbiter_if #(.NREQ(NREQ)) bus();

  clk_div_arbiter #(.NREQ(NREQ), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_i (clk_i),
    .reset (rst),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model: owner selected at edge m_sel, released at edge m_rel, next pick allowed at m_free.
  int              m_edge = 0;
  bit              m_own  = 1'b0;
  int              m_owner = 0;
  int              m_sel = 0;
  int              m_rel = -100;
  int              m_free = 0;
  int              m_ptr = NREQ - 1;
  int              m_last_id = 0;
  logic [31:0]     m_fac = 32'd2;
  logic [NREQ-1:0] e_gnt;
  logic [2:0]      e_id;
  logic            e_busy, e_dr;
  logic [31:0]     e_df;

  typedef struct {
    bit              rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [2:0]      id;
    logic            busy;
    logic            dr;
    logic [31:0]     df;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, m_edge);
  endtask

  task automatic set_fac(input int i, input logic [31:0] v);
    bus.factor[32*i +: 32] = v;
  endtask

  function automatic void model_edge(input bit r, input logic [NREQ-1:0] rq,
                                     input logic [32*NREQ-1:0] f);
    int n;
    logic [31:0] v;
    m_edge++;
    n = m_edge;
    if (r) begin
      m_own = 1'b0; m_last_id = 0; m_fac = 32'd2; m_ptr = NREQ - 1;
      m_rel = -100; m_free = n + 1;
    end else if (m_own) begin
      if (n >= m_sel + 1 && !rq[m_owner]) begin
        m_own = 1'b0; m_rel = n; m_ptr = m_owner; m_free = n + 2;
      end
    end else if (n >= m_free && rq != '0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!m_own && rq[(m_ptr + k) % NREQ]) begin
          m_own = 1'b1; m_owner = (m_ptr + k) % NREQ;
        end
      end
      m_sel = n; m_last_id = m_owner;
      v = f[32*m_owner +: 32];
      m_fac = (v < 2) ? 32'd2 : v;
    end
    e_id = 3'(m_last_id);
    e_df = m_fac;
    if (m_own) begin
      e_busy = 1'b1;
      e_dr   = (n == m_sel);
      e_gnt  = (n >= m_sel + 1 + SETTLE) ? NREQ'(1 << m_owner) : '0;
    end else begin
      e_gnt  = '0;
      e_dr   = 1'b1;
      e_busy = (n == m_rel);
    end
  endfunction

  task automatic step();
    @(posedge clk_i);
    model_edge(rst, bus.req, bus.factor);
    @(negedge clk_i);
    chk("gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("grant_id", 32'(bus.grant_id), 32'(e_id));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("div_reset", 32'(bus.div_reset), 32'(e_dr));
    chk("div_factor", bus.div_factor, e_df);
    chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  initial begin
    int exp_order[5];
    int gap, guard;
    exp_order = '{0, 1, 2, 3, 0};

    rst     = 1'b1;
    bus.req = '0;
    set_fac(0, 32'd10);
    set_fac(1, 32'd7);
    set_fac(2, 32'd0);
    set_fac(3, 32'd1);

    // rst, req, gnt, id, busy, div_reset, div_factor
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b1, 32'd2};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b1, 32'd2};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b1, 32'd2};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0000, 3'd0, 1'b1, 1'b1, 32'd10};
    tbl[4]  = '{1'b0, 4'b0001, 4'b0000, 3'd0, 1'b1, 1'b0, 32'd10};
    tbl[5]  = '{1'b0, 4'b0001, 4'b0000, 3'd0, 1'b1, 1'b0, 32'd10};
    tbl[6]  = '{1'b0, 4'b0001, 4'b0000, 3'd0, 1'b1, 1'b0, 32'd10};
    tbl[7]  = '{1'b0, 4'b0001, 4'b0000, 3'd0, 1'b1, 1'b0, 32'd10};
    tbl[8]  = '{1'b0, 4'b0001, 4'b0001, 3'd0, 1'b1, 1'b0, 32'd10};
    tbl[9]  = '{1'b0, 4'b0001, 4'b0001, 3'd0, 1'b1, 1'b0, 32'd10};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 3'd0, 1'b1, 1'b1, 32'd10};
    tbl[11] = '{1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b1, 32'd10};
    tbl[12] = '{1'b0, 4'b1000, 4'b0000, 3'd3, 1'b1, 1'b1, 32'd2};
    tbl[13] = '{1'b0, 4'b1000, 4'b0000, 3'd3, 1'b1, 1'b0, 32'd2};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 3'd3, 1'b1, 1'b1, 32'd2};
    tbl[15] = '{1'b0, 4'b0100, 4'b0000, 3'd3, 1'b0, 1'b1, 32'd2};
    tbl[16] = '{1'b0, 4'b0100, 4'b0000, 3'd2, 1'b1, 1'b1, 32'd2};
    tbl[17] = '{1'b1, 4'b0100, 4'b0000, 3'd0, 1'b0, 1'b1, 32'd2};

    for (int i = 0; i < 18; i++) begin
      rst     = tbl[i].rst;
      bus.req = tbl[i].req;
      step();
      chk($sformatf("tbl%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_id", i), 32'(bus.grant_id), 32'(tbl[i].id));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_dr", i), 32'(bus.div_reset), 32'(tbl[i].dr));
      chk($sformatf("tbl%0d_df", i), bus.div_factor, tbl[i].df);
    end

    // All four requesting: each owner holds three granted cycles, then drops once.
    rst     = 1'b0;
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      gap = 0;
      guard = 0;
      while (e_gnt == '0 && guard < 40) begin
        step();
        if (bus.gnt == '0) gap++;
        guard++;
      end
      if (e_gnt == '0) begin
        n_total++;
        $display("FAIL rr_wait%0d: no grant within %0d cycles", g, guard);
      end
      chk($sformatf("rr_owner%0d", g), 32'(bus.grant_id), 32'(exp_order[g]));
      if (g > 0) chk($sformatf("rr_gap%0d_ge2", g), 32'(gap >= 2), 32'd1);
      step();
      step();
      bus.req[exp_order[g]] = 1'b0;
      step();
      bus.req = (g == 4) ? 4'b0100 : 4'b1111;
    end

    // Reset while req 2 owns the divider; req 0 must win afterwards.
    guard = 0;
    while (e_gnt == '0 && guard < 40) begin
      step();
      guard++;
    end
    chk("rst_pre_owner", 32'(bus.grant_id), 32'd2);
    chk("rst_pre_gnt", 32'(bus.gnt), 32'b0100);
    rst     = 1'b1;
    bus.req = 4'b0101;
    step();
    chk("rst_gnt_drop", 32'(bus.gnt), 32'd0);
    chk("rst_div_reset", 32'(bus.div_reset), 32'd1);
    rst = 1'b0;
    step();
    chk("rst_next_owner", 32'(bus.grant_id), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
        if ($urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 3))
            0: set_fac(i, 32'd0);
            1: set_fac(i, 32'd1);
            2: set_fac(i, 32'd2);
            default: set_fac(i, $urandom);
          endcase
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
